// File: rtl/hp_combat_engine_pkg.sv
// Shared types and helpers for the combat engine: FSM states, LFSR taps and
// per-attack-type damage parameters.
package combat_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROLL,
    APPLY
  } state_e;

  // Fibonacci taps 16,14,13,11 as a mask over bits [15:0].
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int unsigned base_dmg(input int unsigned k, input int unsigned step);
    return step * (k + 1);
  endfunction

  function automatic int unsigned var_half(input int unsigned k, input int unsigned step);
    return step * (k + 1);
  endfunction

endpackage

// File: rtl/hp_combat_engine_if.sv
// Attack request / result bus between the battle FSM (master) and the
// combat engine (slave); the HUD observes the HP and KO outputs.
interface hp_combat_engine_if #(
  parameter int HP_W  = 8,
  parameter int ATK_W = 2
);

  logic             new_battle;
  logic             atk_valid;
  logic             atk_ready;
  logic             atk_target;
  logic [ATK_W-1:0] atk_type;
  logic             rnd_force_en;
  logic [15:0]      rnd_force;
  logic [HP_W-1:0]  hp_p;
  logic [HP_W-1:0]  hp_e;
  logic             ko_p;
  logic             ko_e;
  logic             res_valid;
  logic             res_hit;
  logic [HP_W-1:0]  res_dmg;

  modport master (
    output new_battle, atk_valid, atk_target, atk_type, rnd_force_en, rnd_force,
    input  atk_ready, hp_p, hp_e, ko_p, ko_e, res_valid, res_hit, res_dmg
  );

  modport slave (
    input  new_battle, atk_valid, atk_target, atk_type, rnd_force_en, rnd_force,
    output atk_ready, hp_p, hp_e, ko_p, ko_e, res_valid, res_hit, res_dmg
  );

endinterface

// File: rtl/hp_combat_engine_lfsr.sv
// Free-running 16-bit Fibonacci LFSR used as the combat randomness source.
module combat_lfsr
  import combat_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] value
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign value = lfsr_q;

endmodule

// File: rtl/hp_combat_engine.sv
// Combat engine: holds both combatants' HP and resolves one attack at a time
// through IDLE -> ROLL -> APPLY.
module hp_combat_engine
  import combat_pkg::*;
#(
  parameter int          HP_W      = 8,
  parameter int          MAX_HP    = 100,
  parameter int          N_ATK     = 4,
  parameter int          ATK_W     = 2,
  parameter int unsigned BASE_STEP = 10,
  parameter int unsigned VAR_STEP  = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic                clk,
  input logic                rst,
  hp_combat_engine_if.slave  bus
);

  localparam int                     RAW_W    = HP_W + 8;
  localparam int unsigned            N_ATK_U  = N_ATK;
  localparam logic [HP_W-1:0]        HP_FULL  = HP_W'(MAX_HP);
  localparam logic signed [RAW_W-1:0] DMG_CEIL = RAW_W'((2 ** HP_W) - 1);

  logic [15:0] lfsr_val;

  combat_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .value (lfsr_val)
  );

  state_e           state_q, state_d;
  logic             target_q, target_d;
  logic [ATK_W-1:0] type_q, type_d;
  logic             hit_q, hit_d;
  logic [HP_W-1:0]  raw_q, raw_d;
  logic [HP_W-1:0]  hp_p_q, hp_p_d, hp_e_q, hp_e_d;
  logic             ko_p_q, ko_p_d, ko_e_q, ko_e_d;
  logic             res_valid_q, res_valid_d, res_hit_q, res_hit_d;
  logic [HP_W-1:0]  res_dmg_q, res_dmg_d;
  logic             atk_ready_q, atk_ready_d;

  // Roll datapath: R[15:12] is the accuracy nibble, R[7:0] scales the variation.
  logic [15:0]              rnd;
  int unsigned              k_u, base_u, half_u, span_u, v_u;
  logic signed [RAW_W-1:0]  raw_s;
  logic                     roll_hit;
  logic [HP_W-1:0]          roll_dmg;
  logic                     unused_rnd;

  always_comb begin
    rnd      = bus.rnd_force_en ? bus.rnd_force : lfsr_val;
    k_u      = 32'(type_q);
    base_u   = base_dmg(k_u, BASE_STEP);
    half_u   = var_half(k_u, VAR_STEP);
    span_u   = 2 * half_u + 1;
    v_u      = (32'(rnd[7:0]) * span_u) >> 8;
    raw_s    = RAW_W'(base_u + v_u) - RAW_W'(half_u);
    roll_hit = (k_u < N_ATK_U) && (32'(rnd[15:12]) > k_u);
    if (raw_s < 0)             roll_dmg = '0;
    else if (raw_s > DMG_CEIL) roll_dmg = '1;
    else                       roll_dmg = raw_s[HP_W-1:0];
  end

  assign unused_rnd = ^rnd[11:8];

  logic [HP_W-1:0] tgt_hp, apply_dmg;

  always_comb begin
    tgt_hp    = target_q ? hp_p_q : hp_e_q;
    apply_dmg = hit_q ? ((raw_q < tgt_hp) ? raw_q : tgt_hp) : '0;
  end

  // NOTE: every _d starts from its _q so no branch can leave a latch behind.
  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    type_d      = type_q;
    hit_d       = hit_q;
    raw_d       = raw_q;
    hp_p_d      = hp_p_q;
    hp_e_d      = hp_e_q;
    res_valid_d = 1'b0;
    res_hit_d   = res_hit_q;
    res_dmg_d   = res_dmg_q;
    atk_ready_d = atk_ready_q;

    if (bus.new_battle) begin
      hp_p_d      = HP_FULL;
      hp_e_d      = HP_FULL;
      state_d     = IDLE;
      atk_ready_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.atk_valid && atk_ready_q) begin
            target_d    = bus.atk_target;
            type_d      = bus.atk_type;
            state_d     = ROLL;
            atk_ready_d = 1'b0;
          end
        end
        ROLL: begin
          hit_d   = roll_hit;
          raw_d   = roll_dmg;
          state_d = APPLY;
        end
        APPLY: begin
          if (target_q) hp_p_d = hp_p_q - apply_dmg;
          else          hp_e_d = hp_e_q - apply_dmg;
          res_valid_d = 1'b1;
          res_hit_d   = hit_q;
          res_dmg_d   = apply_dmg;
          state_d     = IDLE;
          atk_ready_d = 1'b1;
        end
        default: begin
          state_d     = IDLE;
          atk_ready_d = 1'b1;
        end
      endcase
    end

    ko_p_d = (hp_p_d == '0);
    ko_e_d = (hp_e_d == '0);
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      target_q    <= 1'b0;
      type_q      <= '0;
      hit_q       <= 1'b0;
      raw_q       <= '0;
      hp_p_q      <= HP_FULL;
      hp_e_q      <= HP_FULL;
      ko_p_q      <= 1'b0;
      ko_e_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_hit_q   <= 1'b0;
      res_dmg_q   <= '0;
      atk_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      type_q      <= type_d;
      hit_q       <= hit_d;
      raw_q       <= raw_d;
      hp_p_q      <= hp_p_d;
      hp_e_q      <= hp_e_d;
      ko_p_q      <= ko_p_d;
      ko_e_q      <= ko_e_d;
      res_valid_q <= res_valid_d;
      res_hit_q   <= res_hit_d;
      res_dmg_q   <= res_dmg_d;
      atk_ready_q <= atk_ready_d;
    end
  end

  assign bus.atk_ready = atk_ready_q;
  assign bus.hp_p      = hp_p_q;
  assign bus.hp_e      = hp_e_q;
  assign bus.ko_p      = ko_p_q;
  assign bus.ko_e      = ko_e_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_hit   = res_hit_q;
  assign bus.res_dmg   = res_dmg_q;

endmodule

// File: tb/tb_hp_combat_engine.sv
// Self-checking bench for hp_combat_engine: cycle-level transaction model,
// per-cycle output comparison, and directed attacks with literal expectations.
module tb_hp_combat_engine;

  localparam int MAX_HP    = 100;
  localparam int N_ATK     = 4;
  localparam int BASE_STEP = 10;
  localparam int VAR_STEP  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hp_combat_engine_if #(.HP_W(8), .ATK_W(2)) bus ();

  hp_combat_engine #(
    .HP_W(8), .MAX_HP(MAX_HP), .N_ATK(N_ATK), .ATK_W(2),
    .BASE_STEP(BASE_STEP), .VAR_STEP(VAR_STEP), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit roll_hit(input logic [15:0] r, input int k);
    if (k >= N_ATK) return 1'b0;
    return int'(r[15:12]) > k;
  endfunction

  function automatic int roll_raw(input logic [15:0] r, input int k);
    int half, span, v, raw;
    half = VAR_STEP * (k + 1);
    span = 2 * half + 1;
    v    = (int'(r[7:0]) * span) / 256;
    raw  = BASE_STEP * (k + 1) + v - half;
    if (raw < 0)   raw = 0;
    if (raw > 255) raw = 255;
    return raw;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  logic [15:0] m_lfsr, m_r;
  bit          m_on = 1'b0, m_busy, m_tgt, m_rv, m_hit;
  int          m_hp [2];   // [0] enemy, [1] player
  int          m_type, m_dmg, m_pre_hp, m_acc_cyc;
  int          cyc = 0;

  always @(posedge clk) begin
    int raw;
    cyc++;
    if (rst) begin
      m_on = 1'b1; m_lfsr = 16'hACE1; m_busy = 1'b0;
      m_hp[0] = MAX_HP; m_hp[1] = MAX_HP;
      m_rv = 1'b0; m_hit = 1'b0; m_dmg = 0;
    end else begin
      m_rv = 1'b0;
      if (bus.new_battle) begin
        m_hp[0] = MAX_HP; m_hp[1] = MAX_HP; m_busy = 1'b0;
      end else if (m_busy && cyc == m_acc_cyc + 1) begin
        m_r = bus.rnd_force_en ? bus.rnd_force : m_lfsr;
      end else if (m_busy && cyc == m_acc_cyc + 2) begin
        m_pre_hp = m_hp[m_tgt];
        m_hit    = roll_hit(m_r, m_type);
        raw      = roll_raw(m_r, m_type);
        m_dmg    = m_hit ? ((raw < m_pre_hp) ? raw : m_pre_hp) : 0;
        m_hp[m_tgt] = m_pre_hp - m_dmg;
        m_rv   = 1'b1;
        m_busy = 1'b0;
      end else if (!m_busy && bus.atk_valid) begin
        m_busy = 1'b1; m_acc_cyc = cyc;
        m_tgt = bus.atk_target; m_type = int'(bus.atk_type);
      end
      m_lfsr = lfsr_next(m_lfsr);
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      check("atk_ready", 32'(bus.atk_ready), 32'(!m_busy));
      check("hp_p", 32'(bus.hp_p), m_hp[1]);
      check("hp_e", 32'(bus.hp_e), m_hp[0]);
      check("ko_p", 32'(bus.ko_p), 32'(m_hp[1] == 0));
      check("ko_e", 32'(bus.ko_e), 32'(m_hp[0] == 0));
      check("res_valid", 32'(bus.res_valid), 32'(m_rv));
      check("res_hit", 32'(bus.res_hit), 32'(m_hit));
      check("res_dmg", 32'(bus.res_dmg), m_dmg);
      if (bus.res_valid === 1'b1 && bus.res_hit === 1'b1)
        check("dmg_range",
              32'((int'(bus.res_dmg) >= (BASE_STEP - VAR_STEP) * (m_type + 1) &&
                   int'(bus.res_dmg) <= (BASE_STEP + VAR_STEP) * (m_type + 1)) ||
                  int'(bus.res_dmg) == m_pre_hp), 1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic attack(input bit tgt, input int typ, input bit fen, input logic [15:0] fr,
                        output int lat, output bit hit, output int dmg);
    int i;
    lat = -1; hit = 1'b0; dmg = -1;
    @(negedge clk);
    bus.atk_valid = 1'b1; bus.atk_target = tgt; bus.atk_type = 2'(typ);
    bus.rnd_force_en = fen; bus.rnd_force = fr;
    i = 0;
    while (bus.atk_ready !== 1'b1 && i < 20) begin @(negedge clk); i++; end
    if (bus.atk_ready !== 1'b1) begin
      check("accept_timeout", 0, 1);
      bus.atk_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.atk_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (bus.res_valid === 1'b1) begin
        lat = c; hit = bus.res_hit; dmg = int'(bus.res_dmg);
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, dmg, seen, n_acc;
    bit hit;
    int acc_cyc [$];

    rst = 1'b1;
    bus.new_battle = 1'b0; bus.atk_valid = 1'b0; bus.atk_target = 1'b0;
    bus.atk_type = '0; bus.rnd_force_en = 1'b0; bus.rnd_force = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_hp_p", 32'(bus.hp_p), 100);
    check("rst_hp_e", 32'(bus.hp_e), 100);
    check("rst_ko", 32'({bus.ko_p, bus.ko_e}), 0);
    check("rst_ready", 32'(bus.atk_ready), 1);
    check("rst_res_valid", 32'(bus.res_valid), 0);

    // Heavy attacks on the enemy down to KO and beyond.
    attack(1'b0, 3, 1'b1, 16'hF0FF, lat, hit, dmg);
    check("e1_latency", lat, 2); check("e1_hit", 32'(hit), 1);
    check("e1_dmg", dmg, 48);    check("e1_hp_e", 32'(bus.hp_e), 52);
    attack(1'b0, 3, 1'b1, 16'hF0FF, lat, hit, dmg);
    check("e2_dmg", dmg, 48);    check("e2_hp_e", 32'(bus.hp_e), 4);
    attack(1'b0, 3, 1'b1, 16'hF0FF, lat, hit, dmg);
    check("e3_dmg", dmg, 4);     check("e3_hp_e", 32'(bus.hp_e), 0);
    check("e3_ko_e", 32'(bus.ko_e), 1);
    attack(1'b0, 3, 1'b1, 16'hF0FF, lat, hit, dmg);
    check("e4_latency", lat, 2); check("e4_hit", 32'(hit), 1);
    check("e4_dmg", dmg, 0);     check("e4_hp_e", 32'(bus.hp_e), 0);

    // Player: miss, then low and high ends of the variation.
    attack(1'b1, 0, 1'b1, 16'h0000, lat, hit, dmg);
    check("p_miss_hit", 32'(hit), 0); check("p_miss_dmg", dmg, 0);
    check("p_miss_hp_p", 32'(bus.hp_p), 100);
    attack(1'b1, 0, 1'b1, 16'h5000, lat, hit, dmg);
    check("p1_dmg", dmg, 8);     check("p1_hp_p", 32'(bus.hp_p), 92);
    attack(1'b1, 1, 1'b1, 16'h5080, lat, hit, dmg);
    check("p2_dmg", dmg, 20);    check("p2_hp_p", 32'(bus.hp_p), 72);

    // new_battle lands while the attack is in ROLL.
    @(negedge clk);
    bus.atk_valid = 1'b1; bus.atk_target = 1'b1; bus.atk_type = 2'd2;
    bus.rnd_force_en = 1'b1; bus.rnd_force = 16'hF0FF;
    @(posedge clk);
    @(negedge clk);
    bus.atk_valid = 1'b0; bus.new_battle = 1'b1;
    @(negedge clk);
    bus.new_battle = 1'b0;
    check("nb_ready", 32'(bus.atk_ready), 1);
    check("nb_hp_p", 32'(bus.hp_p), 100);
    check("nb_hp_e", 32'(bus.hp_e), 100);
    check("nb_ko", 32'({bus.ko_p, bus.ko_e}), 0);
    seen = 0;
    repeat (4) begin @(negedge clk); if (bus.res_valid === 1'b1) seen++; end
    check("nb_no_result", seen, 0);

    // Back-to-back requests with atk_valid held.
    bus.atk_valid = 1'b1; bus.atk_target = 1'b1; bus.atk_type = 2'd3;
    bus.rnd_force_en = 1'b1; bus.rnd_force = 16'h3FFF;
    for (int i = 0; i < 12; i++) begin
      if (bus.atk_ready === 1'b1) acc_cyc.push_back(cyc);
      @(negedge clk);
    end
    bus.atk_valid = 1'b0;
    n_acc = acc_cyc.size();
    check("b2b_accepts", n_acc, 4);
    for (int i = 1; i < n_acc; i++) check("b2b_gap", acc_cyc[i] - acc_cyc[i-1], 3);
    repeat (3) @(negedge clk);
    check("b2b_hit", 32'(bus.res_hit), 0);
    check("b2b_dmg", 32'(bus.res_dmg), 0);
    check("b2b_hp_p", 32'(bus.hp_p), 100);

    // Unforced run driven by the internal LFSR.
    for (int n = 0; n < 1000; n++) begin
      if (n % 40 == 39) begin
        @(negedge clk) bus.new_battle = 1'b1;
        @(negedge clk) bus.new_battle = 1'b0;
      end
      attack(1'($urandom_range(1, 0)), int'($urandom_range(3, 0)), 1'b0, 16'h0000, lat, hit, dmg);
      check("rand_latency", lat, 2);
      check("rand_hp_bound", 32'(int'(bus.hp_p) <= MAX_HP && int'(bus.hp_e) <= MAX_HP), 1);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
